btn_debounce_arbiter: RTL and testbench
=======================================

# btn_debounce_arbiter

Debounces up to NBTN raw push-buttons/switches with a single shared qualification timer. The timer is time-shared between buttons by a round-robin scheduler, so only one button is qualified at a time. The block sits between the board inputs and the user-interface FSMs. It outputs clean stable levels plus one-cycle press and release strobes.

## Interface
- NBTN, 4: number of button inputs (2..8).
- N, 24: qualification timer width. One qualification window lasts 2^N clock cycles (about 168 ms at 100 MHz).
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the clk rising edge.
- sw  input  NBTN  raw asynchronous button/switch levels.
- db  output  NBTN  debounced stable levels.
- press  output  NBTN  one-cycle strobe when db[i] goes 0→1.
- release  output  NBTN  one-cycle strobe when db[i] goes 1→0.
- busy  output  1  high while a qualification is in progress (state ≠ IDLE).

## Operation
- **Synchronizer:** each sw bit passes through a 2-flop synchronizer, giving ss. All logic below uses ss only.
- **Requests:** req[i] = ss[i] XOR db[i]. A request means a candidate change on button i.
- **Registers:** state, round-robin pointer ptr (ceil(log2 NBTN) bits), selected index sel, timer cnt (N bits).
- **IDLE:**
  - If req = 0: stay in IDLE.
  - Otherwise: sel = first i with req[i] = 1, searching from ptr upward with wrap-around (ptr, ptr+1, …, NBTN-1, 0, …). Clear cnt to 0 and go to QUALIFY.
- **QUALIFY:**
  - If req[sel] = 0 (input bounced back): abort. Go to IDLE, set ptr = (sel+1) mod NBTN, clear cnt. db is unchanged and no strobe is issued.
  - Else if cnt = 2^N−1: commit. Toggle db[sel]. Pulse press[sel] if the new value is 1, otherwise pulse release[sel]. Set ptr = (sel+1) mod NBTN, clear cnt, go to IDLE.
  - Else: cnt = cnt+1, stay in QUALIFY.
- **Other buttons:** changes on buttons other than sel are ignored during QUALIFY. They remain pending as requests and are served later in round-robin order.
- **Counter wrap:** cnt never wraps. The commit check at 2^N−1 takes precedence over the increment.
- **State encoding:** 2 states (IDLE, QUALIFY). Any unused encoding returns to IDLE.
- **Strobes and busy:** press and release are registered and high for exactly one cycle, in the same cycle db changes. At most one strobe bit is high per cycle. busy is registered and equals (state = QUALIFY).

## Timing
- **Reset values:** db = 0, press = 0, release = 0, busy = 0, state = IDLE, ptr = 0, sel = 0, cnt = 0, synchronizer flops = 0.
- **Reset mid-QUALIFY:** the qualification is abandoned and no strobe is issued. After reset is released, an input still held high is re-qualified from scratch.
- **Synchronizer latency:** 2 cycles from a sw change to the ss change.
- **Stable change on an otherwise idle block:**
  - IDLE sees req at edge t.
  - QUALIFY occupies edges t+1 … t+2^N.
  - db and strobe update at edge t+2^N+1, and state returns to IDLE at the same edge.
  - Total latency from sw to db is 2^N+3 cycles.
- **Back-to-back service:** a pending request is granted in the IDLE cycle right after a commit or abort. Simultaneous changes on k buttons commit 2^N+1 cycles apart.
- **Glitch rejection:** a bounce on button sel shorter than 2^N cycles, landing anywhere in QUALIFY, causes an abort. The glitch never appears on db.
- **Release path:** identical timing to the press path.

## Test plan
All scenarios use NBTN = 4, N = 4 (window of 16 cycles).
1. Reset held low for 3 cycles while sw = 4'b1111, then released → db = 0, press = 0 and busy = 0 during reset. busy rises 3 cycles after release. db[0] = 1 with press[0] pulsed at cycle 19 after release.
2. sw[1] goes high and is held; bounce toggles on sw[1] at cycles 5 and 6 of QUALIFY → abort (busy drops, no press). Re-qualification completes: db[1] = 1, press[1] high for exactly 1 cycle, and no other strobe fires.
3. sw = 4'b0110 applied simultaneously with ptr = 0 → db[1] set first, then db[2] set 17 cycles later. press[1] and press[2] are each one cycle wide and never overlap.
4. Round-robin fairness: ptr = 3 after a commit on button 2, then buttons 0 and 3 are requested together → button 3 is served before button 0.
5. Held button 2 released (sw[2] = 0 held) → release[2] pulses once, db[2] = 0 exactly 19 cycles after the sw edge, and press stays 0 throughout.
6. Reset asserted at cycle 8 of QUALIFY → no strobe. The next cycle shows db = 0, busy = 0, cnt = 0.

Source files
------------

// File: rtl/btn_debounce_arbiter_if.sv
// Button bundle between the board and the debouncer: raw levels in,
// debounced levels, press/release strobes and busy out.
interface btn_debounce_arbiter_if #(
    parameter int unsigned NBTN = 4
);
    logic [NBTN-1:0] sw;
    logic [NBTN-1:0] db;
    logic [NBTN-1:0] press;
    logic [NBTN-1:0] rel;
    logic            busy;

    modport master (output sw, input db, press, rel, busy);
    modport slave  (input sw, output db, press, rel, busy);
endinterface

// File: rtl/btn_debounce_arbiter.sv
// Debounces NBTN buttons with one shared 2^N-cycle qualification timer,
// handed out round-robin to buttons whose synchronized level differs from db.
module btn_debounce_arbiter #(
    parameter int unsigned NBTN = 4,
    parameter int unsigned N    = 24
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    btn_debounce_arbiter_if.slave btn
);
    localparam int unsigned PW = (NBTN > 1) ? $clog2(NBTN) : 1;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StQualify = 2'b01
    } state_e;

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   sel_q;
    logic [N-1:0]    cnt_q;
    logic [NBTN-1:0] sync_q;
    logic [NBTN-1:0] ss_q;
    logic [NBTN-1:0] db_q;
    logic [NBTN-1:0] press_q;
    logic [NBTN-1:0] rel_q;
    logic            busy_q;

    logic [NBTN-1:0] req;
    logic            grant_vld;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   cand;
    logic [PW-1:0]   sel_next;

    assign req      = ss_q ^ db_q;
    assign sel_next = (sel_q == PW'(NBTN - 1)) ? '0 : sel_q + PW'(1);

    // First requester at or after ptr, wrapping around.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NBTN; k++) begin
            cand = PW'((32'(ptr_q) + k) % NBTN);
            if (!grant_vld && req[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            sync_q  <= '0;
            ss_q    <= '0;
            db_q    <= '0;
            press_q <= '0;
            rel_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= btn.sw;
            ss_q    <= sync_q;
            press_q <= '0;
            rel_q   <= '0;
            case (state_q)
                StIdle: begin
                    if (grant_vld) begin
                        sel_q   <= grant_idx;
                        cnt_q   <= '0;
                        state_q <= StQualify;
                        busy_q  <= 1'b1;
                    end
                end
                StQualify: begin
                    if (!req[sel_q]) begin
                        // Bounced back before the window closed: drop it silently.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ptr_q   <= sel_next;
                        cnt_q   <= '0;
                    end else if (cnt_q == '1) begin
                        db_q[sel_q] <= ~db_q[sel_q];
                        if (!db_q[sel_q]) begin
                            press_q[sel_q] <= 1'b1;
                        end else begin
                            rel_q[sel_q] <= 1'b1;
                        end
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        ptr_q   <= sel_next;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + N'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn.db    = db_q;
    assign btn.press = press_q;
    assign btn.rel   = rel_q;
    assign btn.busy  = busy_q;

endmodule

// File: tb/tb_btn_debounce_arbiter.sv
// Self-checking bench: directed scenarios plus random bouncing, all compared
// each cycle against a behavioural model of the shared-timer debouncer.
module tb_btn_debounce_arbiter;
    localparam int unsigned NBTN = 4;
    localparam int unsigned N    = 4;
    localparam int          WIN  = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    btn_debounce_arbiter_if #(.NBTN(NBTN)) bus ();

    btn_debounce_arbiter #(.NBTN(NBTN), .N(N)) dut (
        .clk_i   (clk),
        .reset_ni(reset_n),
        .btn     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: owner = button holding the timer (-1 = none),
    // age = cycles it has been held, next = where the search starts.
    bit m_s1[NBTN];
    bit m_ss[NBTN];
    bit m_db[NBTN];
    bit m_pr[NBTN];
    bit m_rl[NBTN];
    int m_owner = -1;
    int m_age   = 0;
    int m_next  = 0;

    always @(posedge clk) begin
        for (int i = 0; i < NBTN; i++) begin
            m_pr[i] = 1'b0;
            m_rl[i] = 1'b0;
        end
        if (!reset_n) begin
            for (int i = 0; i < NBTN; i++) begin
                m_s1[i] = 1'b0;
                m_ss[i] = 1'b0;
                m_db[i] = 1'b0;
            end
            m_owner = -1;
            m_age   = 0;
            m_next  = 0;
        end else begin
            if (m_owner < 0) begin
                for (int k = 0; k < NBTN; k++) begin
                    if (m_owner < 0 && m_ss[(m_next + k) % NBTN] != m_db[(m_next + k) % NBTN]) begin
                        m_owner = (m_next + k) % NBTN;
                        m_age   = 0;
                    end
                end
            end else if (m_ss[m_owner] == m_db[m_owner]) begin
                m_next  = (m_owner + 1) % NBTN;
                m_owner = -1;
            end else if (m_age == WIN - 1) begin
                m_db[m_owner] = !m_db[m_owner];
                if (m_db[m_owner]) m_pr[m_owner] = 1'b1;
                else               m_rl[m_owner] = 1'b1;
                m_next  = (m_owner + 1) % NBTN;
                m_owner = -1;
            end else begin
                m_age++;
            end
            for (int i = 0; i < NBTN; i++) begin
                m_ss[i] = m_s1[i];
                m_s1[i] = bus.sw[i];
            end
        end
    end

    function automatic logic [3*NBTN:0] exp_vec();
        logic [NBTN-1:0] d, p, r;
        for (int i = 0; i < NBTN; i++) begin
            d[i] = m_db[i];
            p[i] = m_pr[i];
            r[i] = m_rl[i];
        end
        return {d, p, r, (m_owner >= 0)};
    endfunction

    function automatic logic [3*NBTN:0] dut_vec();
        return {bus.db, bus.press, bus.rel, bus.busy};
    endfunction

    task automatic test_reset();
        int busy_cyc = 0;
        int press_cyc = 0;
        bus.sw  = 4'b1111;
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec() || bus.db !== '0 || bus.press !== '0 || bus.busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        reset_n = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_run c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (busy_cyc == 0 && bus.busy === 1'b1) busy_cyc = c;
            if (press_cyc == 0 && bus.press[0] === 1'b1) press_cyc = c;
        end
        n_vec++;
        if (busy_cyc != 3) begin
            n_err++;
            $display("FAIL reset_busy_rise got=%0d exp=3", busy_cyc);
        end
        n_vec++;
        if (press_cyc != 19) begin
            n_err++;
            $display("FAIL reset_press0_cycle got=%0d exp=19", press_cyc);
        end
        n_vec++;
        if (bus.db !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_final_db got=%b exp=1111", bus.db);
        end
    endtask

    task automatic test_release_all();
        bus.sw = 4'b0000;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL release_all c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        n_vec++;
        if (bus.db !== 4'b0000) begin
            n_err++;
            $display("FAIL release_all_db got=%b exp=0000", bus.db);
        end
    endtask

    task automatic test_glitch();
        int qcyc = 0;
        int n_press1 = 0;
        int n_other = 0;
        bit was_busy = 1'b0;
        bit aborted = 1'b0;
        bus.sw = 4'b0010;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL glitch c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (was_busy && bus.busy === 1'b0 && n_press1 == 0 && bus.press[1] !== 1'b1) aborted = 1'b1;
            was_busy = (bus.busy === 1'b1);
            if (bus.press[1] === 1'b1) n_press1++;
            n_other += $countones({bus.press & 4'b1101, bus.rel});
            if (bus.busy === 1'b1) qcyc++;
            if (qcyc == 5) bus.sw[1] = 1'b0;
            if (qcyc == 6) bus.sw[1] = 1'b1;
        end
        n_vec++;
        if (!aborted) begin
            n_err++;
            $display("FAIL glitch_abort got=0 exp=1");
        end
        n_vec++;
        if (n_press1 != 1 || n_other != 0) begin
            n_err++;
            $display("FAIL glitch_strobes press1=%0d other=%0d exp=1,0", n_press1, n_other);
        end
        n_vec++;
        if (bus.db !== 4'b0010) begin
            n_err++;
            $display("FAIL glitch_db got=%b exp=0010", bus.db);
        end
    endtask

    task automatic test_simultaneous();
        int p1 = 0;
        int p2 = 0;
        int overlap = 0;
        // Release 1 (ptr->2), then commit 3 so the pointer wraps to 0.
        bus.sw = 4'b0000;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL simul_prep_a c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        bus.sw = 4'b1000;
        for (int c = 1; c <= 25; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL simul_prep_b c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
        end
        bus.sw = 4'b1110;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL simul c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (bus.press[1] === 1'b1) p1 = c;
            if (bus.press[2] === 1'b1) p2 = c;
            if ($countones({bus.press, bus.rel}) > 1) overlap++;
        end
        n_vec++;
        if (p1 != 19 || p2 != 36) begin
            n_err++;
            $display("FAIL simul_order p1=%0d p2=%0d exp=19,36", p1, p2);
        end
        n_vec++;
        if (overlap != 0 || bus.db !== 4'b1110) begin
            n_err++;
            $display("FAIL simul_final overlap=%0d db=%b exp=0,1110", overlap, bus.db);
        end
    endtask

    task automatic test_round_robin();
        int r3 = 0;
        int p0 = 0;
        bus.sw = 4'b0111;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rr c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (bus.rel[3] === 1'b1) r3 = c;
            if (bus.press[0] === 1'b1) p0 = c;
        end
        n_vec++;
        if (r3 != 19 || p0 != 36) begin
            n_err++;
            $display("FAIL rr_order rel3=%0d press0=%0d exp=19,36", r3, p0);
        end
    endtask

    task automatic test_release_path();
        int r2 = 0;
        int n_rel = 0;
        int n_press = 0;
        bus.sw = 4'b0011;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rel_path c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (bus.rel[2] === 1'b1) r2 = c;
            n_rel   += $countones(bus.rel);
            n_press += $countones(bus.press);
            if (c == 18 && bus.db[2] !== 1'b1) begin
                n_err++;
                $display("FAIL rel_path_early got=%b exp=1", bus.db[2]);
            end
        end
        n_vec++;
        if (r2 != 19 || n_rel != 1 || n_press != 0 || bus.db !== 4'b0011) begin
            n_err++;
            $display("FAIL rel_path_sum rel2=%0d nrel=%0d npress=%0d db=%b exp=19,1,0,0011",
                     r2, n_rel, n_press, bus.db);
        end
    endtask

    task automatic test_reset_mid();
        int qcyc = 0;
        int p0 = 0;
        int p1 = 0;
        int p2 = 0;
        bus.sw = 4'b0111;
        for (int c = 1; c <= 20 && qcyc < 8; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rmid_pre c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (bus.busy === 1'b1) qcyc++;
        end
        n_vec++;
        if (qcyc != 8) begin
            n_err++;
            $display("FAIL rmid_qualify_reach got=%0d exp=8", qcyc);
        end
        reset_n = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (bus.db !== '0 || bus.busy !== 1'b0 || bus.press !== '0 || bus.rel !== '0
            || dut.cnt_q !== '0) begin
            n_err++;
            $display("FAIL rmid_reset got=%h cnt=%0d exp=0,0", dut_vec(), dut.cnt_q);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL rmid_post c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if (bus.press[0] === 1'b1) p0 = c;
            if (bus.press[1] === 1'b1) p1 = c;
            if (bus.press[2] === 1'b1) p2 = c;
        end
        n_vec++;
        if (p0 != 19 || p1 != 36 || p2 != 53) begin
            n_err++;
            $display("FAIL rmid_requal p0=%0d p1=%0d p2=%0d exp=19,36,53", p0, p1, p2);
        end
    endtask

    task automatic test_random();
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (dut_vec() !== exp_vec() || $countones({bus.press, bus.rel}) > 1) begin
                n_err++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), exp_vec());
            end
            if ($urandom_range(0, 11) == 0) bus.sw[$urandom_range(0, NBTN - 1)] ^= 1'b1;
        end
    endtask

    initial begin
        bus.sw = '0;
        test_reset();
        test_release_all();
        test_glitch();
        test_simultaneous();
        test_round_robin();
        test_release_path();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
